// File: rtl/pix_pkg.sv
// Shared types for the pixel front-end and the edge-detection pipeline.
package pix_pkg;

  localparam int unsigned PIXEL_W_DEF = 24;
  localparam int unsigned WIN_DEF     = 5;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  typedef enum logic [0:0] {
    FILL,
    STREAM
  } feeder_state_t;

endpackage

// File: rtl/pixel_out_reg.sv
// Single-entry valid/ready output register for pixel windows; holds its contents
// stable until the downstream handshake.
module pixel_out_reg import pix_pkg::*; #(
  parameter int unsigned PIXEL_W = PIXEL_W_DEF,
  parameter int unsigned WIN     = WIN_DEF,
  parameter int unsigned COL_W   = 10
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [PIXEL_W-1:0] pixels_i [WIN],
  input  logic [COL_W-1:0]   col_i,
  input  logic               last_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [PIXEL_W-1:0] pixels_o [WIN],
  output logic [COL_W-1:0]   col_o,
  output logic               last_o
);

  logic               valid_q;
  logic [PIXEL_W-1:0] pixels_q [WIN];
  logic [COL_W-1:0]   col_q;
  logic               last_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      pixels_q <= '{default: '0};
      col_q    <= '0;
      last_q   <= 1'b0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      pixels_q <= pixels_i;
      col_q    <= col_i;
      last_q   <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign pixels_o = pixels_q;
  assign col_o    = col_q;
  assign last_o   = last_q;

endmodule

// File: rtl/pixel_window_feeder.sv
// Turns a raster pixel stream into WIN-pixel sliding windows that never straddle
// a line boundary; early start-of-line markers resynchronise the column count.
module pixel_window_feeder import pix_pkg::*; #(
  parameter int unsigned PIXEL_W  = PIXEL_W_DEF,
  parameter int unsigned WIN      = WIN_DEF,
  parameter int unsigned LINE_LEN = 640,
  parameter int unsigned COL_W    = $clog2(LINE_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_sol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_pixels [WIN],
  output logic [COL_W-1:0]   out_col,
  output logic               out_last,
  output logic               sol_err
);

  localparam int unsigned      FILL_W   = $clog2(WIN);
  localparam logic [COL_W-1:0]  LastCol  = COL_W'(LINE_LEN - 1);
  localparam logic [FILL_W-1:0] FullFill = FILL_W'(WIN - 1);

  feeder_state_t      state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PIXEL_W-1:0] win_q [WIN];
  logic [PIXEL_W-1:0] win_d [WIN];
  logic               sol_err_q;
  logic               accept, resync, eol, load;

  // Filling never touches the output register, so only STREAM needs a free slot.
  assign in_ready = (state_q == FILL) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign resync   = accept && in_sol && (col_q != '0);
  assign eol      = (col_q == LastCol);
  assign load     = accept && !resync && (state_q == STREAM);

  always_comb begin
    for (int unsigned i = 0; i < WIN - 1; i++) begin
      win_d[i] = win_q[i+1];
    end
    win_d[WIN-1] = in_pixel;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    fill_d  = fill_q;
    if (accept) begin
      if (resync) begin
        col_d  = COL_W'(1);
        fill_d = FILL_W'(1);
      end else if (eol) begin
        col_d  = '0;
        fill_d = '0;
      end else begin
        col_d  = col_q + 1'b1;
        fill_d = (fill_q == FullFill) ? fill_q : fill_q + 1'b1;
      end
      state_d = (fill_d == FullFill) ? STREAM : FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      col_q     <= '0;
      fill_q    <= '0;
      sol_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      fill_q    <= fill_d;
      sol_err_q <= resync;
    end
  end

  // Shift register is deliberately unreset; fill count gates its use.
  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  assign sol_err = sol_err_q;

  pixel_out_reg #(
    .PIXEL_W (PIXEL_W),
    .WIN     (WIN),
    .COL_W   (COL_W)
  ) u_out_reg (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .load_i   (load),
    .pixels_i (win_d),
    .col_i    (col_q),
    .last_i   (eol),
    .ready_i  (out_ready),
    .valid_o  (out_valid),
    .pixels_o (out_pixels),
    .col_o    (out_col),
    .last_o   (out_last)
  );

endmodule

// File: tb/tb_pixel_window_feeder.sv
// Scoreboard bench for pixel_window_feeder with an 8-pixel line and 5-pixel window.
module tb_pixel_window_feeder;

  localparam int unsigned PW  = 24;
  localparam int unsigned WIN = 5;
  localparam int unsigned LL  = 8;
  localparam int unsigned CW  = 3;

  typedef struct packed {
    logic [WIN*PW-1:0] pix;
    logic [CW-1:0]     col;
    logic              last;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sol = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          in_ready, out_valid, out_last, sol_err;
  logic [PW-1:0] out_pixels [WIN];
  logic [CW-1:0] out_col;

  int checks = 0;
  int errors = 0;

  win_t          sb[$];
  logic [PW-1:0] line_buf[$];
  bit            exp_sol = 0;
  bit            exp_new = 0;
  bit            rnd_ready = 0;
  int            n_pop = 0;
  int            n_solerr = 0;
  int            cap_idx = -1;
  logic [WIN*PW-1:0] first_pix, last_pix;
  logic [CW-1:0]     first_col, last_col;
  logic              last_last;
  win_t              e_w;

  always #5 clk = ~clk;

  pixel_window_feeder #(
    .PIXEL_W  (PW),
    .WIN      (WIN),
    .LINE_LEN (LL),
    .COL_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sol     (in_sol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixels (out_pixels),
    .out_col    (out_col),
    .out_last   (out_last),
    .sol_err    (sol_err)
  );

  function automatic logic [WIN*PW-1:0] flat_out();
    logic [WIN*PW-1:0] w;
    for (int i = 0; i < WIN; i++) w[i*PW +: PW] = out_pixels[i];
    return w;
  endfunction

  function automatic logic [WIN*PW-1:0] seq_win(int first);
    logic [WIN*PW-1:0] w;
    for (int i = 0; i < WIN; i++) w[i*PW +: PW] = PW'(first + i);
    return w;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: keep the pixels of the current line; every pixel from the WIN-th
  // onward closes a window made of the last WIN pixels of that line.
  task automatic model_accept(logic [PW-1:0] p, logic sol);
    win_t w;
    if (sol && line_buf.size() != 0) begin
      line_buf.delete();
      exp_sol = 1;
    end
    line_buf.push_back(p);
    if (line_buf.size() >= WIN) begin
      for (int i = 0; i < WIN; i++) w.pix[i*PW +: PW] = line_buf[line_buf.size() - WIN + i];
      w.col  = CW'(line_buf.size() - 1);
      w.last = (line_buf.size() == LL);
      sb.push_back(w);
      exp_new = 1;
    end
    if (line_buf.size() == LL) line_buf.delete();
  endtask

  // Monitor: all handshakes are resolved on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      line_buf.delete();
      exp_sol = 0;
      exp_new = 0;
    end else begin
      chk("out_valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, (line_buf.size() < WIN - 1) || sb.size() == 0 || out_ready);
      chk("sol_err", sol_err, exp_sol);
      if (sol_err) n_solerr++;
      if (exp_new) begin
        chk("latency_valid", out_valid, 1'b1);
        if (sb.size() != 0) chk("latency_col", out_col, sb[$].col);
      end
      exp_sol = 0;
      exp_new = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL window_unexpected: got col %0d expected no window", out_col);
        end else begin
          e_w = sb.pop_front();
          chk("win_pixels", flat_out(), e_w.pix);
          chk("win_col", out_col, e_w.col);
          chk("win_last", out_last, e_w.last);
          if (n_pop == cap_idx) begin
            first_pix = flat_out();
            first_col = out_col;
          end
          last_pix  = flat_out();
          last_col  = out_col;
          last_last = out_last;
          n_pop++;
        end
      end
      if (in_valid && in_ready) model_accept(in_pixel, in_sol);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  task automatic send(logic [PW-1:0] p, logic sol, bit gaps);
    int n = 0;
    logic acc;
    if (gaps && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pixel = p;
    in_sol   = sol;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got stall on pixel %0h expected acceptance", p);
        break;
      end
    end
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rnd_ready = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int sbase;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_sol_err", sol_err, 1'b0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_pixels", flat_out(), 0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // One line, free-flowing output.
    out_ready = 1'b1;
    base = n_pop;
    cap_idx = base;
    for (int i = 1; i <= 8; i++) send(PW'(i), i == 1, 0);
    drain();
    chk("t1_count", n_pop - base, 4);
    chk("t1_first_pix", first_pix, seq_win(1));
    chk("t1_first_col", first_col, 4);
    chk("t1_last_pix", last_pix, seq_win(4));
    chk("t1_last_col", last_col, 7);
    chk("t1_last_flag", last_last, 1'b1);

    // Output stalled after the first window.
    out_ready = 1'b0;
    base = n_pop;
    fork
      for (int i = 1; i <= 8; i++) send(PW'(i), 0, 0);
      begin
        automatic int m = 0;
        while (!out_valid && m < 50) begin
          @(posedge clk);
          #1;
          m++;
        end
        chk("t2_valid_seen", out_valid, 1'b1);
        repeat (10) begin
          @(negedge clk);
          chk("t2_hold_pix", flat_out(), seq_win(1));
          chk("t2_hold_col", out_col, 4);
          chk("t2_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t2_count", n_pop - base, 4);
    chk("t2_last_pix", last_pix, seq_win(4));

    // Two lines back to back.
    base = n_pop;
    cap_idx = base + 4;
    for (int i = 1; i <= 16; i++) send(PW'(i), 0, 0);
    drain();
    chk("t3_count", n_pop - base, 8);
    chk("t3_line2_first", first_pix, seq_win(9));
    chk("t3_last_pix", last_pix, seq_win(12));
    chk("t3_last_flag", last_last, 1'b1);

    // Early start-of-line on pixel 3.
    base = n_pop;
    sbase = n_solerr;
    cap_idx = base;
    for (int i = 1; i <= 10; i++) send(PW'(i), i == 1 || i == 3, 0);
    drain();
    chk("t4_solerr_pulses", n_solerr - sbase, 1);
    chk("t4_count", n_pop - base, 4);
    chk("t4_first_pix", first_pix, seq_win(3));
    chk("t4_first_col", first_col, 4);
    chk("t4_last_pix", last_pix, seq_win(6));

    // Reset while a window is pending.
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(PW'(i), 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5_pending", out_valid, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_valid_dropped", out_valid, 1'b0);
    chk("t5_pixels_zero", flat_out(), 0);
    chk("t5_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    base = n_pop;
    cap_idx = base;
    for (int i = 21; i <= 28; i++) send(PW'(i), 0, 0);
    drain();
    chk("t5_count", n_pop - base, 4);
    chk("t5_first_pix", first_pix, seq_win(21));

    // Randomised traffic and backpressure.
    rnd_ready = 1;
    for (int i = 0; i < 1000; i++) send(PW'($urandom), $urandom_range(0, 39) == 0, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_window_feeder.md
Name: pixel_window_feeder

Overview:
- Front-end that feeds the edge-detection pipeline.
- Accepts a raster stream of 24-bit pixels, one per beat, under a valid/ready handshake.
- Emits 5-pixel sliding windows, one per accepted pixel once the window is full, with valid/ready backpressure.
- Never emits a window that straddles a line boundary.

Parameters:
- PIXEL_W, 24, bits per pixel.
- WIN, 5, window length in pixels; legal range 2..16.
- LINE_LEN, 640, pixels per line; must be at least WIN.
- COL_W, $clog2(LINE_LEN), column counter width.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  pixel offered.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_pixel  in  PIXEL_W  pixel data.
- in_sol  in  1  start-of-line marker; qualified by acceptance.
- out_valid  out  1  window available.
- out_ready  in  1  downstream accepts window.
- out_pixels  out  WIN x PIXEL_W  unpacked array; [0] is the oldest pixel, [WIN-1] the newest.
- out_col  out  COL_W  column of out_pixels[WIN-1].
- out_last  out  1  final window of the line.
- sol_err  out  1  one-cycle pulse on an early in_sol resync.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=FILL, col=0, fill=0.
  - out_valid=0, out_last=0, sol_err=0, out_col=0, out_pixels all zero.
  - Window shift register is not cleared.
- Interface:
  - in_ready is combinational from state and the output register only. It never depends on in_valid.
- States:
  - FILL: fewer than WIN-1 pixels of the current line are held.
  - STREAM: WIN-1 pixels are held, so the next accepted pixel completes a window.
- Acceptance (in_valid && in_ready):
  - Pixel shifts into window[WIN-1]; older pixels shift down.
  - col increments; fill saturates at WIN-1.
- in_ready:
  - FILL: 1 always. Shifting does not disturb the separate output register.
  - STREAM: !out_valid || out_ready, i.e. single-entry output register with a combinational pass-through on the ready path.
- Window emission (acceptance in STREAM):
  - Next cycle: out_valid=1, out_pixels = shifted window including the new pixel, out_col = col of the new pixel.
  - Latency is 1 cycle from accepting the completing pixel to out_valid.
- Holding: out_valid, out_pixels, out_col and out_last hold stable while out_valid && !out_ready.
- Output drain: out_valid drops the cycle after the handshake unless a new window loads in the same edge.
  - Back-to-back operation gives 1 window per cycle.
- End of line (acceptance at col == LINE_LEN-1):
  - out_last=1 on that window.
  - col=0, fill=0, state=FILL.
  - Windows per line = LINE_LEN-WIN+1 (636 at defaults).
- FILL to STREAM: when fill reaches WIN-1.
- in_sol handling:
  - Accepted with col==0: no effect.
  - Accepted with col!=0: partial line discarded, sol_err pulses for 1 cycle, and the pixel is treated as column 0 (col=1, fill=1 after the shift, state=FILL).
  - A pending output window is unaffected.
- WIN==LINE_LEN: exactly one window per line, which has out_last=1.
- Reset mid-operation: pending window is dropped with no handshake. in_ready is 1 in the cycle after reset deasserts.
- Arithmetic: col wraps explicitly at LINE_LEN-1, never by width overflow. No pixel arithmetic; data passes bit-exact.

Decomposition:
- Shared package pix_pkg:
  - typedef pixel_t (logic [PIXEL_W-1:0]).
  - Constants PIXEL_W_DEF=24, WIN_DEF=5.
  - typedef enum feeder_state_t {FILL, STREAM}.
- The edge detector reuses pixel_t.
- Natural sub-module: pixel_out_reg, a single-entry valid/ready output register carrying out_pixels, out_col and out_last. The top keeps the counters, state machine and shift register.

Test Plan:
- Reset then LINE_LEN=8, WIN=5, pixels 1..8 streamed with out_ready=1 -> first out_valid one cycle after pixel 5 accepted, out_pixels={1,2,3,4,5} and out_col=4. Four windows total; last={4..8}, out_col=7, out_last=1.
- Same stream with out_ready=0 after the first window -> in_ready=0 while in STREAM with a window pending. The window {1..5} holds stable for 10 cycles. On release, windows {2..6}, {3..7}, {4..8} follow; none lost or duplicated.
- Two lines back-to-back, pixels 1..16 -> second line's first window is {9..13}; no window contains both 8 and 9. Total 8 windows; out_last set on {4..8} and {12..16}.
- in_sol asserted on pixel 3 at col 2 (LINE_LEN=8) -> sol_err pulses 1 cycle. Next window is {3,4,5,6,7} with out_col=4 relative to the resync.
- rst_n=0 for 1 cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_pixels=0, in_ready=1. The following line's first window needs 5 fresh pixels.
- Random in_valid/out_ready (50%), 1000 pixels, scoreboard model -> every window matches the reference sliding window exactly, in order.
